// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO with occupancy flags.
// Optional sticky overflow/underflow flags are enabled by defining SYNC_FIFO_ERR_EN.
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_AF_THRESH  = 14;
  localparam int DEF_AE_THRESH  = 2;

  // Pointer width: RAM address bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: DEPTH x DATA_WIDTH, one synchronous write port and one
// asynchronous read port. Contents are not reset.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Store the incoming word on an accepted write.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with full/empty/almost flags and a registered occupancy count.
// FWFT=0 gives a registered 1-cycle read; FWFT=1 shows the head word directly.
// Define SYNC_FIFO_ERR_EN to add the sticky overflow/underflow ports.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_THRESH  = DEF_AF_THRESH,
  parameter int AE_THRESH  = DEF_AE_THRESH,
  parameter int FWFT       = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    r_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
`ifdef SYNC_FIFO_ERR_EN
  output logic                    overflow,
  output logic                    underflow,
`endif
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  localparam logic [PW-1:0] L_DEPTH = PW'(DEPTH);
  localparam logic [PW-1:0] L_AF    = PW'(AF_THRESH);
  localparam logic [PW-1:0] L_AE    = PW'(AE_THRESH);

  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [PW-1:0]         r_count;
  logic [PW-1:0]         w_wptr_nxt;
  logic [PW-1:0]         w_rptr_nxt;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic [DATA_WIDTH-1:0] w_rdata;

  // A read needs a word present; a write needs room, or a same-cycle pop freeing one.
  assign w_rd_ok = r_en && !empty;
  assign w_wr_ok = w_en && (!full || w_rd_ok);

  assign w_wptr_nxt = r_wptr + PW'(w_wr_ok);
  assign w_rptr_nxt = r_rptr + PW'(w_rd_ok);

  // Pointers advance on accepted transfers; the count is the modular pointer
  // distance, which the wrap bit keeps unambiguous over 0..DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_count <= w_wptr_nxt - w_rptr_nxt;
    end
  end

  assign count        = r_count;
  assign full         = (r_count == L_DEPTH);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= L_AF);
  assign almost_empty = (r_count <= L_AE);

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_ok),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (data_in),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is visible whenever the FIFO holds data; zero while empty.
      assign data_out = empty ? '0 : w_rdata;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_dout;

      // Capture the head word on an accepted read; hold otherwise.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_dout <= '0;
        else if (w_rd_ok) r_dout <= w_rdata;
      end

      assign data_out = r_dout;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_EN
  logic r_ovf;
  logic r_udf;

  // Sticky error flags: a dropped write or a read against an empty FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_en && !w_wr_ok) r_ovf <= 1'b1;
      if (r_en && empty)    r_udf <= 1'b1;
    end
  end

  assign overflow  = r_ovf;
  assign underflow = r_udf;
`endif

endmodule
